// File: rtl/pipe_add_if.sv
// Operand/result stream bundle for pipe_add.
// master drives operands and accepts results; slave is the adder.
interface pipe_add_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // A beat moves on a rising edge where valid & ready are both high.
    // valid never depends on ready.
    // A producer holding valid with ready low keeps its data stable.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_add.sv
// Pipelined ripple-carry adder/subtractor.
// Each stage adds one SEG-bit slice, and the carry is registered between slices.
module pipe_add #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic      clk,
    input  logic      rst,
    pipe_add_if.slave io_bus
);
    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $fatal(1, "pipe_add: WIDTH must be a positive multiple of STAGES");
    end

    localparam int SEG = WIDTH / STAGES;

    logic w_en;
    logic w_out_valid;

    // The whole pipe advances or stalls as one.
    // Bubbles keep their slot.
    assign w_en = io_bus.out_ready | ~w_out_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * SEG;  // operand bits still unconsumed on entry
        localparam int DONE = (k + 1) * SEG;    // finished sum bits on exit

        logic [REM-1:0]  w_a_in;
        logic [REM-1:0]  w_b_in;
        logic            w_c_in;
        logic            w_v_in;
        logic [SEG:0]    w_seg;
        logic [DONE-1:0] w_sum_next;

        logic            r_valid;
        logic            r_carry;
        logic [DONE-1:0] r_sum;

        if (k == 0) begin : g_head
            // Subtraction folds into an inverted B and a forced carry-in here.
            // After this point the stages never see sub.
            assign w_a_in     = io_bus.a;
            assign w_b_in     = io_bus.sub ? ~io_bus.b : io_bus.b;
            assign w_c_in     = io_bus.sub | io_bus.cin;
            assign w_v_in     = io_bus.in_valid;
            assign w_sum_next = w_seg[SEG-1:0];
        end else begin : g_body
            assign w_a_in     = g_stage[k-1].g_pass.r_a;
            assign w_b_in     = g_stage[k-1].g_pass.r_b;
            assign w_c_in     = g_stage[k-1].r_carry;
            assign w_v_in     = g_stage[k-1].r_valid;
            assign w_sum_next = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
        end

        assign w_seg = {1'b0, w_a_in[SEG-1:0]} + {1'b0, w_b_in[SEG-1:0]}
                     + {{SEG{1'b0}}, w_c_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_en) begin
                r_valid <= w_v_in;
                r_carry <= w_seg[SEG];
                r_sum   <= w_sum_next;
            end
        end

        if (k < STAGES - 1) begin : g_pass
            logic [REM-SEG-1:0] r_a;
            logic [REM-SEG-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a_in[REM-1:SEG];
                    r_b <= w_b_in[REM-1:SEG];
                end
            end
        end else begin : g_tail
            logic r_ovf;

            // Overflow: operand sign bits agree, but the result sign differs from them.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= (w_a_in[REM-1] == w_b_in[REM-1])
                           & (w_seg[SEG-1] != w_a_in[REM-1]);
                end
            end
        end
    end

    assign w_out_valid      = g_stage[STAGES-1].r_valid;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.in_ready  = w_en;
    assign io_bus.sum       = g_stage[STAGES-1].r_sum;
    assign io_bus.cout      = g_stage[STAGES-1].r_carry;
    assign io_bus.ovf       = g_stage[STAGES-1].g_tail.r_ovf;
endmodule
